mac_array_param: RTL and testbench
==================================

// Module: mac_array_param
// PURPOSE
// - Parametrised successor to the fixed 4x64-bit MAC array: signed fixed-point dot-product engine for the VAE datapath.
// - Per beat: multiplies LANES = NUM_CH*CH_W/ELEM_W activation/weight lane pairs and sums them in an adder tree.
// - Accumulates beats until in_last, then adds bias, rounds, saturates and presents one OUT_W result.
// - Valid/ready on both input and output; sits between the DMA input streams and the activation/writeback stage.
// PARAMETERS
// - NUM_CH    4   : DMA channels per operand
// - CH_W      64  : bits per channel; must be a multiple of ELEM_W
// - ELEM_W    16  : signed lane width, Q(ELEM_W-FRAC_W).FRAC_W
// - FRAC_W    8   : fraction bits of operands, bias and output
// - OUT_W     16  : result width (same Q format as operands)
// - MAX_BEATS 256 : beats per vector guaranteed wrap-free
// - ACC_W     48  : accumulator width; must be >= 2*ELEM_W + clog2(LANES) + clog2(MAX_BEATS)
// PORTS
// - clk        in   1              : clock
// - rst        in   1              : synchronous reset, active-high
// - clr        in   1              : synchronous soft clear; same effect as rst
// - act_data   in   NUM_CH*CH_W    : activation lanes; lane i = bits [i*ELEM_W +: ELEM_W]
// - wgt_data   in   NUM_CH*CH_W    : weight lanes, same packing as act_data
// - bias       in   OUT_W          : signed bias, sampled on the cycle the in_last beat is accepted
// - in_valid   in   1              : beat valid
// - in_last    in   1              : final beat of the vector
// - in_ready   out  1              : beat accepted when in_valid && in_ready
// - dot_product out OUT_W          : result
// - out_valid  out  1              : result valid
// - out_ready  in   1              : result consumed when out_valid && out_ready
// - sat        out  1              : result was clipped; qualified by out_valid
// - ovf        out  1              : more than MAX_BEATS beats in this vector; sticky until result consumed
// BEHAVIOUR
// - Reset values (rst or clr): dot_product=0, out_valid=0, sat=0, ovf=0, in_ready=0 for that cycle.
// - All pipeline registers, the accumulator and the beat counter clear; FSM goes to ACCUM.
// - clr overrides rst-free operation in any state: a vector in flight is discarded and the pending result is dropped.
// - FSM states and in_ready:
//   - ACCUM (in_ready=1): on accept of a beat with in_last, latch bias and go to DRAIN.
//   - DRAIN (in_ready=0): wait for the pipeline to empty, then go to OUT.
//   - OUT (in_ready=0, out_valid=1): on out_ready go to ACCUM.
// - Pipeline:
//   - S1: register the LANES signed products, each 2*ELEM_W bits.
//   - S2: register the adder-tree sum, sign-extended to ACC_W.
//   - S3: acc += sum.
// - Finalisation:
//   - r = (acc + 2^(FRAC_W-1)) >>> FRAC_W (round half up), then r += sign-extended bias.
//   - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 if clipped.
//   - Result, flags and state are registered in the same cycle.
// - Latency: last beat accepted at edge t -> out_valid=1 after edge t+3; next beat accepted earliest the cycle after out_ready.
// - Back-to-back beats in ACCUM: one per cycle, no bubbles required.
// - Output hold: dot_product, sat and ovf are stable while out_valid && !out_ready.
// - Single-beat vector (in_valid && in_last on first beat) is legal.
// - in_last is ignored when in_valid=0.
// - Beat counter saturates at MAX_BEATS+1; ovf=1 once it exceeds MAX_BEATS.
// - Beyond MAX_BEATS the accumulator wraps in two's complement.
// CONFIGURATION
// - MAC_ARRAY_RELU_EN defined: after saturation, a negative result becomes 0; sat keeps its pre-ReLU value.
// - MAC_ARRAY_RELU_EN undefined: signed result passed through unchanged.
// TESTING
// - Defaults; 16 lanes act=0x0100, wgt=0x0100, bias=0, one beat with in_last -> dot_product=0x1000, sat=0, out_valid 3 cycles after accept.
// - Same lanes, 2 beats, bias=0x0080 -> dot_product=0x2080.
// - All lanes act=0x7FFF, wgt=0x7FFF, 4 beats -> dot_product=0x7FFF, sat=1.
// - act=0x0100, wgt=0xFF00, 1 beat -> 0xF000 without RELU_EN; 0x0000 with MAC_ARRAY_RELU_EN.
// - Hold out_ready=0 for 5 cycles -> out_valid, dot_product stable, in_ready=0; out_ready=1 -> in_ready=1 the next cycle.
// - clr after 2 of 3 beats, then a fresh 1-beat vector of ones -> 0x1000, with no residue from the discarded vector.

Source files
------------

// File: rtl/mac_array_param.sv
// mac_array_param: parametrised signed fixed-point dot-product engine.
// Each beat multiplies LANES activation/weight pairs and reduces them in an
// adder tree. Beats accumulate until in_last, then the result is rounded,
// biased, saturated to OUT_W and held under a valid/ready handshake.
// Optional feature macro: MAC_ARRAY_RELU_EN (negative results clamp to zero).
module mac_array_param #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 64,
    parameter int ELEM_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int OUT_W     = 16,
    parameter int MAX_BEATS = 256,
    parameter int ACC_W     = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NUM_CH*CH_W-1:0]   act_data,
    input  logic [NUM_CH*CH_W-1:0]   wgt_data,
    input  logic [OUT_W-1:0]         bias,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         dot_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat,
    output logic                     ovf
);
    localparam int LANES  = (NUM_CH * CH_W) / ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int CNT_W  = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] RND_K = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'($signed({1'b0, {(OUT_W-1){1'b1}}}));
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'($signed({1'b1, {(OUT_W-1){1'b0}}}));

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [ELEM_W-1:0] act_lane_s [LANES];
    logic signed [ELEM_W-1:0] wgt_lane_s [LANES];
    logic signed [PROD_W-1:0] prod_d     [LANES];
    logic signed [PROD_W-1:0] prod_q     [LANES];
    logic signed [ACC_W-1:0]  sum_d, sum_q, acc_q;
    logic                     v1_q, v2_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ovf_q;
    logic signed [OUT_W-1:0]  bias_q;
    logic [OUT_W-1:0]         dot_q;
    logic                     out_valid_q, sat_q;

    logic soft_rst_s, in_ready_s, accept_s, load_res_s, consume_s;
    logic signed [ACC_W-1:0] rnd_s;
    logic signed [ACC_W:0]   res_s;
    logic [OUT_W-1:0]        clip_s, fin_s;
    logic                    sat_s;

    assign soft_rst_s = rst | clr;
    assign accept_s   = in_valid & in_ready_s;

    // Split the packed buses into signed lanes and form the lane products.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            act_lane_s[i] = act_data[i*ELEM_W +: ELEM_W];
            wgt_lane_s[i] = wgt_data[i*ELEM_W +: ELEM_W];
            prod_d[i]     = PROD_W'(act_lane_s[i]) * PROD_W'(wgt_lane_s[i]);
        end
    end

    // Adder tree over the registered products, sign-extended to ACC_W.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
    end

    // Pipeline stages S1 (products) and S2 (tree sum) with their valid flags.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            sum_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            if (accept_s) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end
            if (v1_q) begin
                sum_q <= sum_d;
            end
            v1_q <= accept_s;
            v2_q <= v1_q;
        end
    end

    // Accumulator (S3), beat counter, overflow flag and bias latch; all
    // vector state is cleared once the result has been handed off.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            bias_q <= '0;
        end else if (consume_s) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (v2_q) begin
                acc_q <= acc_q + sum_q;
            end
            if (accept_s) begin
                if (cnt_q != CNT_SAT) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
                if (cnt_q >= CNT_MAX) begin
                    ovf_q <= 1'b1;
                end
                if (in_last) begin
                    bias_q <= bias;
                end
            end
        end
    end

    // Round half up, add bias, saturate, then optionally clamp negatives.
    always_comb begin
        rnd_s = (acc_q + RND_K) >>> FRAC_W;
        res_s = (ACC_W+1)'(rnd_s) + (ACC_W+1)'(bias_q);
        if (res_s > OUT_MAX) begin
            clip_s = {1'b0, {(OUT_W-1){1'b1}}};
            sat_s  = 1'b1;
        end else if (res_s < OUT_MIN) begin
            clip_s = {1'b1, {(OUT_W-1){1'b0}}};
            sat_s  = 1'b1;
        end else begin
            clip_s = res_s[OUT_W-1:0];
            sat_s  = 1'b0;
        end
`ifdef MAC_ARRAY_RELU_EN
        if (clip_s[OUT_W-1]) begin
            fin_s = '0;
        end else begin
            fin_s = clip_s;
        end
`else
        fin_s = clip_s;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DRAIN ends when both pipeline stages are empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept_s && in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (!v1_q && !v2_q) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // FSM output decode: input handshake, result load and result consume.
    always_comb begin
        in_ready_s = 1'b0;
        load_res_s = 1'b0;
        consume_s  = 1'b0;
        case (state_q)
            ST_ACCUM: in_ready_s = ~soft_rst_s;
            ST_DRAIN: load_res_s = ~v1_q & ~v2_q;
            ST_OUT:   consume_s  = out_ready;
            default:  in_ready_s = 1'b0;
        endcase
    end

    // Result registers: loaded with the state change into OUT, held until consumed.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            dot_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (load_res_s) begin
            dot_q       <= fin_s;
            sat_q       <= sat_s;
            out_valid_q <= 1'b1;
        end else if (consume_s) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready    = in_ready_s;
    assign dot_product = dot_q;
    assign sat         = sat_q;
    assign out_valid   = out_valid_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_mac_array_param.sv
// Scoreboard bench for mac_array_param: directed vectors push their expected
// result into a queue; a monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_mac_array_param;
    localparam int BUS = 256;

    logic             clk = 1'b0;
    logic             rst, clr;
    logic [BUS-1:0]   act_data, wgt_data;
    logic [15:0]      bias;
    logic             in_valid, in_last, in_ready;
    logic [15:0]      dot_product;
    logic             out_valid, out_ready, sat, ovf;

    typedef struct packed {
        logic [15:0] dot;
        logic        sat;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mac_array_param dut (
        .clk(clk), .rst(rst), .clr(clr),
        .act_data(act_data), .wgt_data(wgt_data), .bias(bias),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .dot_product(dot_product), .out_valid(out_valid), .out_ready(out_ready),
        .sat(sat), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [BUS-1:0] rep(input logic [15:0] e);
        logic [BUS-1:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = e;
        return r;
    endfunction

    function automatic logic [BUS-1:0] lane0(input logic [15:0] e);
        logic [BUS-1:0] r;
        r = '0;
        r[15:0] = e;
        return r;
    endfunction

    task automatic expect_res(input logic [15:0] d, input logic s, input logic o);
        exp_t e;
        e.dot = d;
        e.sat = s;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Drive one vector of nb identical beats; optional idle gap with in_last=1.
    task automatic send(input logic [BUS-1:0] a, input logic [BUS-1:0] w,
                        input int nb, input logic [15:0] b, input logic gap);
        int g;
        for (int k = 0; k < nb; k++) begin
            act_data = a;
            wgt_data = w;
            bias     = b;
            in_valid = 1'b1;
            in_last  = (k == nb - 1);
            g = 0;
            while (in_ready !== 1'b1 && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 50) timeout("in_ready_wait");
            @(posedge clk); #1;
            if (gap && k != nb - 1) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 1000) timeout("scoreboard_drain");
        @(posedge clk); #1;
    endtask

    // Monitor: compare every result at the handshake against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got dot=0x%04h with nothing expected", dot_product);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_dot", {16'h0000, dot_product}, {16'h0000, e.dot});
                    chk("sb_sat", {31'd0, sat}, {31'd0, e.sat});
                    chk("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
                end
            end
        end
    end

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [BUS-1:0] mix;
        logic [15:0] exp_neg, exp_nsat, exp_rneg;
`ifdef MAC_ARRAY_RELU_EN
        exp_neg  = 16'h0000;
        exp_nsat = 16'h0000;
        exp_rneg = 16'h0000;
`else
        exp_neg  = 16'hF000;
        exp_nsat = 16'h8000;
        exp_rneg = 16'hFFFF;
`endif
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        act_data = '0; wgt_data = '0; bias = 16'h0000; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_dot", {16'h0000, dot_product}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Ones, single beat, plus latency of exactly three edges.
        expect_res(16'h1000, 1'b0, 1'b0);
        send(rep(16'h0100), rep(16'h0100), 1, 16'h0000, 1'b0);
        chk("lat_t0", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("latency", {31'd0, out_valid}, (k == 3) ? 32'd1 : 32'd0);
        end
        wait_drain();

        // Two beats with an idle in_last gap, bias 0.5.
        expect_res(16'h2080, 1'b0, 1'b0);
        send(rep(16'h0100), rep(16'h0100), 2, 16'h0080, 1'b1);
        wait_drain();

        // Mixed lanes (i+1)*0.5 summed = 68, bias -1 -> 67; then positive
        // saturation, queued back-to-back.
        for (int i = 0; i < 16; i++) mix[i*16 +: 16] = 16'((i + 1) * 256);
        expect_res(16'h4300, 1'b0, 1'b0);
        send(mix, rep(16'h0080), 1, 16'hFF00, 1'b0);
        expect_res(16'h7FFF, 1'b1, 1'b0);
        send(rep(16'h7FFF), rep(16'h7FFF), 4, 16'h0000, 1'b0);
        expect_res(exp_nsat, 1'b1, 1'b0);
        send(rep(16'h7FFF), rep(16'h8000), 4, 16'h0000, 1'b0);
        expect_res(exp_neg, 1'b0, 1'b0);
        send(rep(16'h0100), rep(16'hFF00), 1, 16'h0000, 1'b0);
        expect_res(16'h0001, 1'b0, 1'b0);
        send(lane0(16'h0001), lane0(16'h0080), 1, 16'h0000, 1'b0);
        expect_res(exp_rneg, 1'b0, 1'b0);
        send(lane0(16'h0001), lane0(16'hFF7F), 1, 16'h0000, 1'b0);
        wait_drain();

        // Output hold under back-pressure.
        out_ready = 1'b0;
        expect_res(16'h1000, 1'b0, 1'b0);
        send(rep(16'h0100), rep(16'h0100), 1, 16'h0000, 1'b0);
        g = 0;
        while (out_valid !== 1'b1 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) timeout("hold_out_valid");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_dot", {16'h0000, dot_product}, 32'h1000);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);

        // Soft clear after 2 of 3 beats discards the partial vector.
        act_data = rep(16'h7FFF); wgt_data = rep(16'h7FFF);
        in_valid = 1'b1; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr = 1'b1;
        #1;
        chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_in_ready_after", {31'd0, in_ready}, 32'd1);
        expect_res(16'h1000, 1'b0, 1'b0);
        send(rep(16'h0100), rep(16'h0100), 1, 16'h0000, 1'b0);
        wait_drain();

        // Beat-count boundary: 256 beats no overflow, 257 beats overflow.
        expect_res(16'h0010, 1'b0, 1'b0);
        send(rep(16'h0001), rep(16'h0001), 256, 16'h0000, 1'b0);
        wait_drain();
        expect_res(16'h0010, 1'b0, 1'b1);
        send(rep(16'h0001), rep(16'h0001), 257, 16'h0000, 1'b0);
        wait_drain();
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
